// File: rtl/decimal_to_bcd_keypad.sv
// Ten-key decimal keypad encoder: synchronises, debounces and priority-encodes
// key lines y0..y9 into a registered BCD digit with a one-cycle strobe per press.
module decimal_to_bcd_keypad #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y0,
    input  logic y1,
    input  logic y2,
    input  logic y3,
    input  logic y4,
    input  logic y5,
    input  logic y6,
    input  logic y7,
    input  logic y8,
    input  logic y9,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic strobe,
    output logic multi
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    raw;
    logic [9:0]    meta_q, sync_q;
    logic [9:0]    cap_q, cap_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          cnt_done;
    logic [3:0]    digit_q, digit_d, enc;
    logic          strobe_q, strobe_d;
    logic          multi_q, multi_d;
    logic          many;

    assign raw = {y9, y8, y7, y6, y5, y4, y3, y2, y1, y0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Ascending scan: the highest-numbered active line overwrites lower ones.
    always_comb begin
        enc = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (cap_q[i]) enc = 4'(i);
        end
    end

    assign many     = ($countones(cap_q) > 1);
    assign cnt_inc  = cnt_q + CW'(1);
    assign cnt_done = (cnt_inc == CW'(DEBOUNCE_CYCLES));

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        multi_d  = multi_q;
        strobe_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q != '0) begin
                    cap_d   = sync_q;
                    cnt_d   = CW'(1);
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sync_q != cap_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_done) begin
                        digit_d  = enc;
                        multi_d  = many;
                        strobe_d = 1'b1;
                        state_d  = PRESSED;
                    end
                end
            end
            PRESSED: begin
                if (sync_q == '0) begin
                    cnt_d   = CW'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sync_q != '0) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_done) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cap_q    <= '0;
            cnt_q    <= '0;
            digit_q  <= '0;
            strobe_q <= 1'b0;
            multi_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            strobe_q <= strobe_d;
            multi_q  <= multi_d;
        end
    end

    assign {a, b, c, d} = digit_q;
    assign strobe       = strobe_q;
    assign multi        = multi_q;

endmodule
